// File: rtl/fpmul_arbiter.sv
// Round-robin arbiter sharing one FP multiplier among NREQ requesters.
// One operation in flight; a watchdog forces an error response if the multiplier never answers.
module fpmul_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [32*NREQ-1:0]    req_a,
  input  logic [32*NREQ-1:0]    req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [31:0]           rsp_c,
  output logic                  rsp_overflow,
  output logic                  rsp_timeout,
  input  logic                  rsp_ready,
  output logic                  mul_start,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  input  logic [31:0]           mul_c,
  input  logic                  mul_overflow,
  input  logic                  mul_done,
  output logic                  busy
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_gid;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic [31:0]     r_c;
  logic            r_ovf;
  logic            r_tmo;
  logic [CW-1:0]   r_cnt;

  logic [NREQ-1:0] w_shift;
  logic            w_gnt_any;
  logic [IDW-1:0]  w_gnt_id;
  logic [31:0]     w_sel_a;
  logic [31:0]     w_sel_b;
  logic            w_term;
  logic [IDW-1:0]  w_ptr_nxt;

  // Rotate requests so bit 0 is rr_ptr; the lowest set bit wins.
  always_comb begin
    w_shift   = NREQ'({req_valid, req_valid} >> r_rr_ptr);
    w_gnt_any = |req_valid;
    w_gnt_id  = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (w_shift[k]) w_gnt_id = IDW'((int'(r_rr_ptr) + k) % int'(NREQ));
    end
    w_sel_a = '0;
    w_sel_b = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (w_gnt_id == IDW'(k)) begin
        w_sel_a = req_a[32*k +: 32];
        w_sel_b = req_b[32*k +: 32];
      end
    end
  end

  assign w_term    = (r_cnt == CW'(TIMEOUT - 1));
  assign w_ptr_nxt = (r_gid == IDW'(NREQ - 1)) ? '0 : r_gid + IDW'(1);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and output decode; everything is forced low during reset.
  always_comb begin
    w_state_nxt  = r_state;
    req_ready    = '0;
    rsp_valid    = 1'b0;
    rsp_id       = '0;
    rsp_c        = '0;
    rsp_overflow = 1'b0;
    rsp_timeout  = 1'b0;
    mul_start    = 1'b0;
    mul_a        = '0;
    mul_b        = '0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_any) w_state_nxt = S_ISSUE;
        if (w_gnt_any && !reset) req_ready = NREQ'(1) << w_gnt_id;
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
        mul_start   = !reset;
        mul_a       = reset ? '0 : r_a;
        mul_b       = reset ? '0 : r_b;
        busy        = !reset;
      end
      S_WAIT: begin
        if (mul_done || w_term) w_state_nxt = S_RESP;
        mul_a = reset ? '0 : r_a;
        mul_b = reset ? '0 : r_b;
        busy  = !reset;
      end
      S_RESP: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
        if (!reset) begin
          rsp_valid    = 1'b1;
          rsp_id       = r_gid;
          rsp_c        = r_c;
          rsp_overflow = r_ovf;
          rsp_timeout  = r_tmo;
          busy         = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand/result latches, watchdog counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= '0;
      r_gid    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_ovf    <= 1'b0;
      r_tmo    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_any) begin
            r_gid <= w_gnt_id;
            r_a   <= w_sel_a;
            r_b   <= w_sel_b;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (mul_done) begin
            r_c   <= mul_c;
            r_ovf <= mul_overflow;
            r_tmo <= 1'b0;
          end else if (w_term) begin
            r_c   <= 32'hFFFF_FFFF;
            r_ovf <= 1'b1;
            r_tmo <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) r_rr_ptr <= w_ptr_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fpmul_arbiter.md
FPMUL_ARBITER -- requirements
Module: fpmul_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one FP multiplier.
REQ-002 Parameter TIMEOUT, default 64: maximum cycles in WAIT before a forced error response.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_a  input  32*NREQ  IEEE-754 single operand A; requester i uses bits [32i+31:32i].
REQ-007 req_b  input  32*NREQ  operand B, packed the same way as req_a.
REQ-008 req_ready  output  NREQ  one-hot accept strobe.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_id  output  log2(NREQ)  index of the requester owning the result.
REQ-011 rsp_c  output  32  product.
REQ-012 rsp_overflow  output  1  overflow/exception flag.
REQ-013 rsp_timeout  output  1  result was forced by timeout.
REQ-014 rsp_ready  input  1  response consumer accepts.
REQ-015 mul_start  output  1  one-cycle start pulse to the multiplier.
REQ-016 mul_a  output  32  operand A to the multiplier.
REQ-017 mul_b  output  32  operand B to the multiplier.
REQ-018 mul_c  input  32  multiplier result.
REQ-019 mul_overflow  input  1  multiplier overflow flag.
REQ-020 mul_done  input  1  multiplier completion strobe.
REQ-021 busy  output  1  high in any state other than IDLE.

Function
REQ-022 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; exactly one operation is in flight at a time.
REQ-023 In IDLE, the grant SHALL go to the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
REQ-024 In IDLE, req_ready[g] SHALL be high combinationally for the granted index g and low for all others; req_ready SHALL be all-zero in every other state.
REQ-025 On accept (req_valid[g] & req_ready[g]), the block SHALL latch g, req_a[g] and req_b[g] into internal registers and move to ISSUE.
REQ-026 ISSUE SHALL assert mul_start for exactly one cycle, clear the timeout counter, and move to WAIT.
REQ-027 mul_a and mul_b SHALL drive the latched operands from ISSUE through WAIT; they SHALL be zero in IDLE and RESP.
REQ-028 In WAIT, the counter SHALL increment each cycle; mul_done=1 SHALL latch mul_c and mul_overflow, clear the timeout flag, and move to RESP.
REQ-029 Timeout: if the counter reaches TIMEOUT-1 without mul_done, the block SHALL latch c=32'hFFFFFFFF, overflow=1 and timeout=1, then move to RESP.
REQ-030 If mul_done coincides with the timeout terminal count, mul_done SHALL win: the normal result is latched and timeout=0.
REQ-031 mul_done SHALL be ignored outside WAIT, including a mul_done in the ISSUE cycle.
REQ-032 RESP SHALL hold rsp_valid=1 with stable rsp_id, rsp_c, rsp_overflow and rsp_timeout until rsp_ready=1.
REQ-033 On the rsp_ready handshake, rr_ptr SHALL become (g+1) mod NREQ and the FSM SHALL return to IDLE.
REQ-034 When the FSM returns to IDLE, a new accept MAY occur in that same IDLE cycle.
REQ-035 Minimum latency SHALL be: accept at cycle T; mul_start at T+1; mul_done at T+1+L; rsp_valid at T+2+L.
REQ-036 The arbiter SHALL pass mul_c and mul_overflow through unmodified; it performs no arithmetic on them.

Reset
REQ-037 With reset=1 at a clock edge, the next state SHALL be IDLE, rr_ptr=0, the counter and all latched registers 0.
REQ-038 While in reset, all outputs SHALL be 0.
REQ-039 Reset in any state SHALL abandon the in-flight operation: no response is produced, and mul_done arriving after reset is ignored.

Verification
REQ-040 Basic multiply: req_valid=0001, a=3F800000, b=40000000, model returns L=3 -> mul_start one cycle after accept; rsp_id=0, rsp_c=40000000, overflow=0, timeout=0.
REQ-041 Round robin: req_valid=1111 held, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0; a=40400000, b=40000000 gives rsp_c=40C00000 for each.
REQ-042 Overflow pass-through: a=7F000000, b=7F000000, model returns FFFFFFFF with overflow=1 -> rsp_c=FFFFFFFF, rsp_overflow=1, rsp_timeout=0.
REQ-043 Timeout: model never asserts mul_done -> rsp_valid TIMEOUT cycles after entering WAIT, rsp_c=FFFFFFFF, overflow=1, timeout=1; a mul_done on the terminal cycle instead gives timeout=0.
REQ-044 Backpressure: rsp_ready=0 for 10 cycles -> rsp_* stable, req_ready=0000 throughout, busy=1.
REQ-045 Reset during WAIT -> IDLE on the next cycle; a late mul_done produces no rsp_valid; the next grant goes to requester 0.
